// File: rtl/commit_trace_buffer.sv
// Commit/exception trace capture: forms per-cycle trace records in program order
// and queues them in a DEPTH-entry FIFO drained over a valid/ready stream.
module commit_trace_buffer #(
    parameter int NR_PORTS = 2,
    parameter int DEPTH    = 8,
    parameter int VLEN     = 39,
    parameter int XLEN     = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              cycle_i,
    input  logic [1:0]               priv_lvl_i,
    input  logic                     debug_mode_i,
    input  logic [NR_PORTS-1:0]      commit_valid_i,
    input  logic [NR_PORTS*VLEN-1:0] pc_i,
    input  logic [NR_PORTS*32-1:0]   instr_i,
    input  logic [NR_PORTS*5-1:0]    rd_i,
    input  logic [NR_PORTS-1:0]      rd_fpr_i,
    input  logic [NR_PORTS*XLEN-1:0] wdata_i,
    input  logic                     exc_valid_i,
    input  logic [VLEN-1:0]          exc_pc_i,
    input  logic [31:0]              exc_tval_i,
    input  logic [XLEN-1:0]          exc_cause_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [1:0]               rec_type_o,
    output logic [31:0]              rec_cycle_o,
    output logic [1:0]               rec_mode_o,
    output logic [63:0]              rec_pc_o,
    output logic [31:0]              rec_instr_o,
    output logic [4:0]               rec_rd_o,
    output logic [XLEN-1:0]          rec_data_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NC    = NR_PORTS + 1;

    typedef struct packed {
        logic [1:0]      typ;
        logic [31:0]     cycle;
        logic [1:0]      mode;
        logic [63:0]     pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             cand [NC];
    rec_t             head;
    logic [NC-1:0]    cand_vld;
    logic [PTR_W-1:0] slot_off [NC];
    logic [CNT_W-1:0] n_rec, free, count, pushed;
    logic [PTR_W-1:0] wptr, rptr;
    logic [1:0]       mode;
    logic             admit, pop, exc_keep;
    logic [16:0]      drop_sum;

    assign mode     = debug_mode_i ? 2'd2 : priv_lvl_i;
    assign exc_keep = exc_valid_i && (exc_cause_i != XLEN'(2)) &&
                      !((exc_cause_i == XLEN'(24)) && !debug_mode_i);

    // Candidates in program order (ports, then exception); each valid one gets
    // the next consecutive slot offset from the write pointer.
    always_comb begin
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < NC; j++) begin
            cand[j]     = '0;
            cand_vld[j] = 1'b0;
            slot_off[j] = '0;
        end
        for (int i = 0; i < NR_PORTS; i++) begin
            cand_vld[i]    = commit_valid_i[i];
            cand[i].typ    = rd_fpr_i[i] ? 2'd2 : ((rd_i[i*5 +: 5] == 5'd0) ? 2'd0 : 2'd1);
            cand[i].cycle  = cycle_i;
            cand[i].mode   = mode;
            cand[i].pc     = 64'(pc_i[i*VLEN +: VLEN]);
            cand[i].instr  = instr_i[i*32 +: 32];
            cand[i].rd     = rd_i[i*5 +: 5];
            cand[i].data   = (cand[i].typ == 2'd0) ? '0 : wdata_i[i*XLEN +: XLEN];
        end
        cand_vld[NR_PORTS]     = exc_keep;
        cand[NR_PORTS].typ     = 2'd3;
        cand[NR_PORTS].cycle   = cycle_i;
        cand[NR_PORTS].mode    = mode;
        cand[NR_PORTS].pc      = 64'(exc_pc_i);
        cand[NR_PORTS].instr   = exc_tval_i;
        cand[NR_PORTS].data    = exc_cause_i;
        for (int j = 0; j < NC; j++) begin
            slot_off[j] = acc[PTR_W-1:0];
            acc         = acc + CNT_W'(cand_vld[j]);
        end
        n_rec = acc;
    end

    // Free space ignores a same-edge pop so admission never depends on the sink.
    assign free     = CNT_W'(DEPTH) - count;
    assign admit    = (n_rec <= free);
    assign pushed   = admit ? n_rec : '0;
    assign pop      = rec_valid_o && rec_ready_i;
    assign drop_sum = {1'b0, drop_cnt_o} + 17'(n_rec);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (admit)
                wptr <= wptr + PTR_W'(n_rec);
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count + pushed - CNT_W'(pop);
            if (!admit) begin
                drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && admit)
            for (int j = 0; j < NC; j++)
                if (cand_vld[j])
                    mem[wptr + slot_off[j]] <= cand[j];
    end

    assign rec_valid_o = (count != '0);
    assign head        = rec_valid_o ? mem[rptr] : '0;
    assign rec_type_o  = head.typ;
    assign rec_cycle_o = head.cycle;
    assign rec_mode_o  = head.mode;
    assign rec_pc_o    = head.pc;
    assign rec_instr_o = head.instr;
    assign rec_rd_o    = head.rd;
    assign rec_data_o  = head.data;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: vector table plus hand sequences, records
// checked against an expected-record queue as the sink accepts them.
module tb_commit_trace_buffer;
    localparam int NR_PORTS = 2;
    localparam int DEPTH    = 8;
    localparam int VLEN     = 39;
    localparam int XLEN     = 64;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic [31:0]              cycle_i;
    logic [1:0]               priv_lvl_i;
    logic                     debug_mode_i;
    logic [NR_PORTS-1:0]      commit_valid_i;
    logic [NR_PORTS*VLEN-1:0] pc_i;
    logic [NR_PORTS*32-1:0]   instr_i;
    logic [NR_PORTS*5-1:0]    rd_i;
    logic [NR_PORTS-1:0]      rd_fpr_i;
    logic [NR_PORTS*XLEN-1:0] wdata_i;
    logic                     exc_valid_i;
    logic [VLEN-1:0]          exc_pc_i;
    logic [31:0]              exc_tval_i;
    logic [XLEN-1:0]          exc_cause_i;
    logic                     rec_valid_o, rec_ready_i;
    logic [1:0]               rec_type_o, rec_mode_o;
    logic [31:0]              rec_cycle_o, rec_instr_o;
    logic [63:0]              rec_pc_o;
    logic [4:0]               rec_rd_o;
    logic [XLEN-1:0]          rec_data_o;
    logic [15:0]              drop_cnt_o;
    logic                     overflow_o;

    commit_trace_buffer #(.NR_PORTS(NR_PORTS), .DEPTH(DEPTH), .VLEN(VLEN), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst_i), .cycle_i(cycle_i), .priv_lvl_i(priv_lvl_i),
        .debug_mode_i(debug_mode_i), .commit_valid_i(commit_valid_i), .pc_i(pc_i),
        .instr_i(instr_i), .rd_i(rd_i), .rd_fpr_i(rd_fpr_i), .wdata_i(wdata_i),
        .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .exc_cause_i(exc_cause_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_type_o(rec_type_o), .rec_cycle_o(rec_cycle_o), .rec_mode_o(rec_mode_o),
        .rec_pc_o(rec_pc_o), .rec_instr_o(rec_instr_o), .rec_rd_o(rec_rd_o),
        .rec_data_o(rec_data_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] cyc;
        logic [1:0]  mode;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  cv;
        logic [4:0]  rd0;  logic fpr0; logic [63:0] wd0;
        logic [4:0]  rd1;  logic fpr1; logic [63:0] wd1;
        logic        ev;   logic [63:0] cause; logic dbg; logic [1:0] priv;
        int          n;    logic [1:0]  emode;
        logic [1:0]  src [3];
        logic [1:0]  et [3];
        logic [63:0] ed [3];
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Sink side: every accepted record must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rec_valid_o && rec_ready_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_record: got pc %0h, expected no record", rec_pc_o);
            end else begin
                e = sb.pop_front();
                chk("rec_type",  64'(rec_type_o),  64'(e.typ));
                chk("rec_cycle", 64'(rec_cycle_o), 64'(e.cyc));
                chk("rec_mode",  64'(rec_mode_o),  64'(e.mode));
                chk("rec_pc",    rec_pc_o,         e.pc);
                chk("rec_instr", 64'(rec_instr_o), 64'(e.instr));
                chk("rec_rd",    64'(rec_rd_o),    64'(e.rd));
                chk("rec_data",  rec_data_o,       e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        commit_valid_i = '0;
        rd_fpr_i       = '0;
        exc_valid_i    = 1'b0;
    endtask

    task automatic drv_commit(input int p, input logic [VLEN-1:0] pc, input logic [31:0] ins,
                              input logic [4:0] rd, input logic fpr, input logic [63:0] wd);
        commit_valid_i[p]        = 1'b1;
        pc_i[p*VLEN +: VLEN]     = pc;
        instr_i[p*32 +: 32]      = ins;
        rd_i[p*5 +: 5]           = rd;
        rd_fpr_i[p]              = fpr;
        wdata_i[p*XLEN +: XLEN]  = wd;
    endtask

    task automatic drv_exc(input logic [VLEN-1:0] pc, input logic [31:0] tval, input logic [63:0] cause);
        exc_valid_i = 1'b1;
        exc_pc_i    = pc;
        exc_tval_i  = tval;
        exc_cause_i = cause;
    endtask

    task automatic push_exp(input logic [1:0] t, input logic [31:0] c, input logic [1:0] m,
                            input logic [63:0] pc, input logic [31:0] ins, input logic [4:0] rd,
                            input logic [63:0] d);
        exp_t e;
        e.typ = t; e.cyc = c; e.mode = m; e.pc = pc; e.instr = ins; e.rd = rd; e.data = d;
        sb.push_back(e);
    endtask

    function automatic vec_t mkv(input logic [1:0] cv,
                                 input logic [4:0] rd0, input logic fpr0, input logic [63:0] wd0,
                                 input logic [4:0] rd1, input logic fpr1, input logic [63:0] wd1,
                                 input logic ev, input logic [63:0] cause, input logic dbg,
                                 input logic [1:0] priv, input int n, input logic [1:0] emode,
                                 input logic [1:0] s0, input logic [1:0] t0, input logic [63:0] d0,
                                 input logic [1:0] s1, input logic [1:0] t1, input logic [63:0] d1,
                                 input logic [1:0] s2, input logic [1:0] t2, input logic [63:0] d2);
        vec_t v;
        v.cv = cv; v.rd0 = rd0; v.fpr0 = fpr0; v.wd0 = wd0; v.rd1 = rd1; v.fpr1 = fpr1; v.wd1 = wd1;
        v.ev = ev; v.cause = cause; v.dbg = dbg; v.priv = priv; v.n = n; v.emode = emode;
        v.src[0] = s0; v.et[0] = t0; v.ed[0] = d0;
        v.src[1] = s1; v.et[1] = t1; v.ed[1] = d1;
        v.src[2] = s2; v.et[2] = t2; v.ed[2] = d2;
        return v;
    endfunction

    localparam int NV = 11;
    vec_t            vt [NV];
    vec_t            v;
    logic [VLEN-1:0] pc0, pc1, epc;
    logic [31:0]     in0, in1, tv;

    initial begin
        // src: 0 = port 0, 1 = port 1, 2 = exception
        vt[0]  = mkv(2'b01, 1, 0, 64'd5,    0, 0, 0,        0, 0,  0, 3, 1, 3, 0,1,64'd5,    0,0,0,        0,0,0);
        vt[1]  = mkv(2'b11, 2, 0, 64'h1111, 3, 0, 64'h2222, 1, 13, 0, 3, 3, 3, 0,1,64'h1111, 1,1,64'h2222, 2,3,64'd13);
        vt[2]  = mkv(2'b00, 0, 0, 0,        0, 0, 0,        1, 2,  0, 3, 0, 3, 0,0,0,        0,0,0,        0,0,0);
        vt[3]  = mkv(2'b00, 0, 0, 0,        0, 0, 0,        1, 24, 0, 1, 0, 1, 0,0,0,        0,0,0,        0,0,0);
        vt[4]  = mkv(2'b00, 0, 0, 0,        0, 0, 0,        1, 24, 1, 0, 1, 2, 2,3,64'd24,   0,0,0,        0,0,0);
        vt[5]  = mkv(2'b01, 0, 0, 64'hFF,   0, 0, 0,        0, 0,  0, 0, 1, 0, 0,0,64'd0,    0,0,0,        0,0,0);
        vt[6]  = mkv(2'b01, 0, 1, 64'h3FF0000000000000, 0, 0, 0, 0, 0, 0, 1, 1, 1,
                     0,2,64'h3FF0000000000000, 0,0,0, 0,0,0);
        vt[7]  = mkv(2'b10, 0, 0, 0,        7, 0, 64'hCAFE, 0, 0,  0, 1, 1, 1, 1,1,64'hCAFE, 0,0,0,        0,0,0);
        vt[8]  = mkv(2'b01, 4, 0, 64'd9,    0, 0, 0,        1, 2,  0, 3, 1, 3, 0,1,64'd9,    0,0,0,        0,0,0);
        vt[9]  = mkv(2'b11, 3, 1, 64'h4000000000000000, 0, 0, 64'h55, 0, 0, 0, 0, 2, 0,
                     0,2,64'h4000000000000000, 1,0,64'd0, 0,0,0);
        vt[10] = mkv(2'b01, 31, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 1, 24, 1, 3, 2, 2,
                     0,1,64'hFFFFFFFFFFFFFFFF, 2,3,64'd24, 0,0,0);

        rst_i = 1'b1; cycle_i = '0; priv_lvl_i = 2'd3; debug_mode_i = 1'b0;
        commit_valid_i = '0; pc_i = '0; instr_i = '0; rd_i = '0; rd_fpr_i = '0; wdata_i = '0;
        exc_valid_i = 1'b0; exc_pc_i = '0; exc_tval_i = '0; exc_cause_i = '0; rec_ready_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        chk("reset_valid", 64'(rec_valid_o), 64'd0);
        chk("reset_type",  64'(rec_type_o),  64'd0);
        chk("reset_pc",    rec_pc_o,         64'd0);
        chk("reset_data",  rec_data_o,       64'd0);
        chk("reset_drop",  64'(drop_cnt_o),  64'd0);
        chk("reset_ovf",   64'(overflow_o),  64'd0);
        mon_en = 1'b1;

        // Single commit
        cycle_i = 32'd10; priv_lvl_i = 2'd3;
        drv_commit(0, 39'h80000000, 32'h00500093, 5'd1, 1'b0, 64'd5);
        push_exp(2'd1, 32'd10, 2'd3, 64'h0000000080000000, 32'h00500093, 5'd1, 64'd5);
        tick(); clr();
        chk("single_valid", 64'(rec_valid_o), 64'd1);
        tick();
        chk("single_after_valid", 64'(rec_valid_o), 64'd0);

        // Vector table
        for (int k = 0; k < NV; k++) begin
            v = vt[k];
            cycle_i = 32'd1000 + 32'(k); priv_lvl_i = v.priv; debug_mode_i = v.dbg;
            pc0 = 39'h1000 + 39'(k * 16); pc1 = pc0 + 39'd4; epc = 39'h7F000000 + 39'(k);
            in0 = 32'hA0000000 + 32'(k); in1 = 32'hB0000000 + 32'(k); tv = 32'hDEAD0000 + 32'(k);
            if (v.cv[0]) drv_commit(0, pc0, in0, v.rd0, v.fpr0, v.wd0);
            if (v.cv[1]) drv_commit(1, pc1, in1, v.rd1, v.fpr1, v.wd1);
            if (v.ev)    drv_exc(epc, tv, v.cause);
            for (int j = 0; j < v.n; j++) begin
                case (v.src[j])
                    2'd0:    push_exp(v.et[j], cycle_i, v.emode, 64'(pc0), in0, v.rd0, v.ed[j]);
                    2'd1:    push_exp(v.et[j], cycle_i, v.emode, 64'(pc1), in1, v.rd1, v.ed[j]);
                    default: push_exp(v.et[j], cycle_i, v.emode, 64'(epc), tv,  5'd0,  v.ed[j]);
                endcase
            end
            tick(); clr();
            chk($sformatf("vec%0d_valid", k), 64'(rec_valid_o), 64'(v.n != 0));
            repeat (4) tick();
            chk($sformatf("vec%0d_drained", k), 64'(rec_valid_o), 64'd0);
        end
        chk("vec_drop", 64'(drop_cnt_o), 64'd0);
        debug_mode_i = 1'b0; priv_lvl_i = 2'd3;

        // Overflow with a stalled sink
        rec_ready_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cycle_i = 32'd200 + 32'(k);
            drv_commit(0, 39'h3000 + 39'(4 * k), 32'h2000 + 32'(k), 5'(k + 1), 1'b0, 64'h100 + 64'(k));
            if (k < 8)
                push_exp(2'd1, cycle_i, 2'd3, 64'h3000 + 64'(4 * k), 32'h2000 + 32'(k), 5'(k + 1), 64'h100 + 64'(k));
            tick(); clr();
            chk("stall_pc", rec_pc_o, 64'h3000);
            chk("stall_data", rec_data_o, 64'h100);
            if (k == 7) chk("full_no_drop", 64'(drop_cnt_o), 64'd0);
        end
        chk("ovf_drop1", 64'(drop_cnt_o), 64'd1);
        chk("ovf_flag",  64'(overflow_o), 64'd1);
        drv_commit(0, 39'h5000, 32'h1, 5'd1, 1'b0, 64'd1);
        drv_commit(1, 39'h5004, 32'h2, 5'd2, 1'b0, 64'd2);
        tick(); clr();
        chk("ovf_drop3", 64'(drop_cnt_o), 64'd3);
        chk("ovf_head_pc", rec_pc_o, 64'h3000);
        // Full FIFO: pop and 1-record push on the same edge; push is dropped.
        rec_ready_i = 1'b1;
        drv_commit(0, 39'h6000, 32'h3, 5'd3, 1'b0, 64'd3);
        tick(); clr();
        chk("full_pop_push_drop", 64'(drop_cnt_o), 64'd4);
        repeat (10) tick();
        chk("ovf_drained_valid", 64'(rec_valid_o), 64'd0);
        chk("ovf_drained_all", 64'(sb.size()), 64'd0);

        // Reset mid-stream
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("rst1_drop", 64'(drop_cnt_o), 64'd0);
        rec_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle_i = 32'd300 + 32'(k);
            drv_commit(0, 39'h4000 + 39'(8 * k), 32'h40 + 32'(k), 5'd5, 1'b0, 64'h500 + 64'(k));
            if (k != 2) drv_commit(1, 39'h4004 + 39'(8 * k), 32'h80 + 32'(k), 5'd6, 1'b0, 64'h600 + 64'(k));
            if (k < 2) drv_exc(39'h4800 + 39'(k), 32'hC0 + 32'(k), 64'd13);
            if (k < 3) begin
                push_exp(2'd1, cycle_i, 2'd3, 64'h4000 + 64'(8 * k), 32'h40 + 32'(k), 5'd5, 64'h500 + 64'(k));
                if (k != 2) push_exp(2'd1, cycle_i, 2'd3, 64'h4004 + 64'(8 * k), 32'h80 + 32'(k), 5'd6, 64'h600 + 64'(k));
                if (k < 2) push_exp(2'd3, cycle_i, 2'd3, 64'h4800 + 64'(k), 32'hC0 + 32'(k), 5'd0, 64'd13);
            end
            tick(); clr();
        end
        chk("pre_rst_drop", 64'(drop_cnt_o), 64'd2);
        chk("pre_rst_ovf",  64'(overflow_o), 64'd1);
        rec_ready_i = 1'b1;
        repeat (2) tick();
        rec_ready_i = 1'b0;
        chk("pre_rst_valid", 64'(rec_valid_o), 64'd1);
        chk("pre_rst_left", 64'(sb.size()), 64'd5);
        rst_i = 1'b1;
        drv_commit(0, 39'h9000, 32'h99, 5'd9, 1'b0, 64'h99);
        tick(); clr(); rst_i = 1'b0;
        sb.delete();
        chk("rst_valid", 64'(rec_valid_o), 64'd0);
        chk("rst_drop",  64'(drop_cnt_o),  64'd0);
        chk("rst_ovf",   64'(overflow_o),  64'd0);
        chk("rst_pc",    rec_pc_o,         64'd0);
        rec_ready_i = 1'b1; cycle_i = 32'd400;
        drv_commit(0, 39'hA000, 32'hAA, 5'd10, 1'b0, 64'hAAAA);
        push_exp(2'd1, 32'd400, 2'd3, 64'hA000, 32'hAA, 5'd10, 64'hAAAA);
        tick(); clr();
        chk("post_rst_valid", 64'(rec_valid_o), 64'd1);
        tick();
        chk("post_rst_done", 64'(rec_valid_o), 64'd0);
        chk("post_rst_all", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
